// File: rtl/acia_master.sv
// Polling bus master for a 6850-style ACIA: it reads the status register every
// POLL_GAP cycles and moves one byte per poll between the ACIA and ready/valid streams.
module acia_master #(
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned RDRF_BIT = 3,
    parameter int unsigned TDRE_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       wr,
    output logic       rd,
    output logic [1:0] regSel,
    output logic [7:0] busOut,
    input  logic [7:0] busIn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready
);

    localparam logic [2:0] GAP      = 3'd0;
    localparam logic [2:0] RD_STAT  = 3'd1;
    localparam logic [2:0] CAP_STAT = 3'd2;
    localparam logic [2:0] RD_DATA  = 3'd3;
    localparam logic [2:0] CAP_DATA = 3'd4;
    localparam logic [2:0] WR_DATA  = 3'd5;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_STAT = 2'b01;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [7:0] gap_cnt;

    // RX wins over TX, but only when there is room to hold the byte.
    always_comb begin
        next_state = GAP;
        case (state)
            GAP:      next_state = (gap_cnt == GAP_LAST) ? RD_STAT : GAP;
            RD_STAT:  next_state = CAP_STAT;
            CAP_STAT: begin
                if (busIn[RDRF_BIT] && !rx_valid)
                    next_state = RD_DATA;
                else if (busIn[TDRE_BIT] && tx_valid)
                    next_state = WR_DATA;
                else
                    next_state = GAP;
            end
            RD_DATA:  next_state = CAP_DATA;
            CAP_DATA: next_state = GAP;
            WR_DATA:  next_state = GAP;
            default:  next_state = GAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= GAP;
            gap_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == GAP && gap_cnt != GAP_LAST)
                gap_cnt <= gap_cnt + 8'd1;
            else
                gap_cnt <= '0;
        end
    end

    // CAP_DATA is only entered with rx_valid low, so capture and consume never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (state == CAP_DATA) begin
            rx_valid <= 1'b1;
            rx_data  <= busIn;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    always_comb begin
        rd       = (state == RD_STAT) || (state == RD_DATA);
        wr       = (state == WR_DATA);
        regSel   = (state == RD_DATA || state == WR_DATA) ? SEL_DATA : SEL_STAT;
        busOut   = (state == WR_DATA) ? tx_data : '0;
        tx_ready = (state == WR_DATA) && tx_valid;
    end

endmodule

// File: tb/tb_acia_master.sv
// Directed bench for acia_master: one table row per status poll, plus hand-written
// sequences for repeated TX starvation and reset during a data capture.
module tb_acia_master;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr, rd;
    logic [1:0] regSel;
    logic [7:0] busOut;
    logic [7:0] busIn = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int viol = 0;

    acia_master #(.POLL_GAP(P), .RDRF_BIT(3), .TDRE_BIT(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .regSel(regSel),
        .busOut(busOut), .busIn(busIn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] status;
        logic [7:0] data;
        logic       txv;
        logic [7:0] txd;
        logic       rxr;
        int         kind;     // 0 no transfer, 1 data read, 2 data write
        logic       exp_rxv;
        logic [7:0] exp_rxd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd && wr) viol++;
    endtask

    // Counts cycles until the next status read strobe; idle cycles must be quiet.
    task automatic wait_rd_stat(output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (!rd && (wr || tx_ready || busOut != 8'h00 || regSel != 2'b01)) viol++;
        end while (!rd && n < 64);
    endtask

    task automatic run_poll(input vec_t v, input string tag);
        int n;
        int kind;
        wait_rd_stat(n);
        check({tag, "_gap"}, n, P);
        check({tag, "_stat_sel"}, {rd, wr, regSel}, 4'b1001);
        busIn = v.status;
        tick();
        check({tag, "_cap_stat_quiet"}, {rd, wr, regSel}, 4'b0001);
        tick();
        kind = 0;
        if (rd && regSel == 2'b00) begin
            kind = 1;
            busIn = v.data;
            tick();
            if (rd || wr) viol++;
            tick();
        end else if (wr) begin
            kind = 2;
            check({tag, "_wr_bus"}, {busOut, regSel, tx_ready}, {v.txd, 2'b00, 1'b1});
            tick();
            if (wr || tx_ready) viol++;
        end
        check({tag, "_kind"}, kind, v.kind);
        check({tag, "_rx"}, {rx_valid, rx_data}, {v.exp_rxv, v.exp_rxd});
        busIn = 8'h00;
    endtask

    initial begin
        int n;
        vec_t idle_tx;

        vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00};
        vecs[1]  = '{8'h08, 8'h41, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h41};
        vecs[2]  = '{8'h18, 8'hEE, 1'b1, 8'h5A, 1'b0, 2, 1'b1, 8'h41};
        vecs[3]  = '{8'h08, 8'h77, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h41};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h41};
        vecs[5]  = '{8'h18, 8'h33, 1'b1, 8'hA5, 1'b0, 1, 1'b1, 8'h33};
        vecs[6]  = '{8'h18, 8'h99, 1'b1, 8'hA5, 1'b0, 2, 1'b1, 8'h33};
        vecs[7]  = '{8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b1, 8'h33};
        vecs[8]  = '{8'h10, 8'h00, 1'b1, 8'hC3, 1'b1, 2, 1'b0, 8'h33};
        vecs[9]  = '{8'h08, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h00};
        vecs[10] = '{8'hE7, 8'h00, 1'b1, 8'h3C, 1'b0, 0, 1'b1, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {rd, wr, tx_ready}, 3'b000);
        check("reset_regsel", regSel, 2'b01);
        check("reset_busout", busOut, 8'h00);
        check("reset_rx", {rx_valid, rx_data}, 9'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            tx_valid = vecs[i].txv;
            tx_data  = vecs[i].txd;
            rx_ready = vecs[i].rxr;
            run_poll(vecs[i], $sformatf("vec%0d", i));
        end

        // TX data pending but the transmitter never reports empty.
        idle_tx = '{8'h00, 8'h00, 1'b1, 8'h11, 1'b0, 0, 1'b1, 8'h00};
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        rx_ready = 1'b0;
        for (int i = 0; i < 10; i++) run_poll(idle_tx, $sformatf("txstall%0d", i));

        // Reset arriving while a received byte is being captured.
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        wait_rd_stat(n);
        check("abort_gap", n, P);
        busIn = 8'h08;
        tick();
        tick();
        check("abort_rd_data", {rd, regSel}, 3'b100);
        busIn = 8'h55;
        tick();
        reset = 1'b1;
        #1;
        check("abort_strobes", {rd, wr, tx_ready, regSel}, 5'b00001);
        check("abort_busout", busOut, 8'h00);
        check("abort_rx", {rx_valid, rx_data}, 9'h000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        busIn = 8'h00;
        wait_rd_stat(n);
        check("abort_first_poll", n, P);
        check("abort_rx_after", rx_valid, 1'b0);

        check("strobe_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acia_master.md
ACIA_MASTER -- requirements
Module: acia_master

Interface
REQ-001 Parameter POLL_GAP, default 16: idle cycles between status polls, legal range 1..255.
REQ-002 Parameter RDRF_BIT, default 3: status bit meaning "receive data register full".
REQ-003 Parameter TDRE_BIT, default 4: status bit meaning "transmit data register empty".
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 wr  output  1  single-cycle ACIA register write strobe.
REQ-007 rd  output  1  single-cycle ACIA register read strobe.
REQ-008 regSel  output  2  ACIA register select: 2'b00 data, 2'b01 status.
REQ-009 busOut  output  8  write data to ACIA; meaningful only while wr=1.
REQ-010 busIn  input  8  ACIA read data; valid the cycle after rd=1.
REQ-011 tx_data  input  8  byte to transmit.
REQ-012 tx_valid  input  1  tx_data holds a byte.
REQ-013 tx_ready  output  1  byte accepted when tx_valid&tx_ready.
REQ-014 rx_data  output  8  received byte.
REQ-015 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-016 rx_ready  input  1  consumer takes byte when rx_valid&rx_ready.

Function
REQ-017 FSM states: GAP, RD_STAT, CAP_STAT, RD_DATA, CAP_DATA, WR_DATA.
REQ-018 GAP: 8-bit counter counts 0..POLL_GAP-1 while in GAP; on reaching POLL_GAP-1 -> RD_STAT and counter clears.
REQ-019 RD_STAT: rd=1, regSel=01 for exactly one cycle -> CAP_STAT.
REQ-020 CAP_STAT: status captured from busIn; transition priority: (RDRF=1 and rx_valid=0) -> RD_DATA; else (TDRE=1 and tx_valid=1) -> WR_DATA; else -> GAP.
REQ-021 RD_DATA: rd=1, regSel=00 for one cycle -> CAP_DATA.
REQ-022 CAP_DATA: rx_data<=busIn, rx_valid<=1 on exit edge -> GAP.
REQ-023 WR_DATA: wr=1, regSel=00, busOut=tx_data, tx_ready=1 for exactly one cycle -> GAP; tx_data consumed that cycle.
REQ-024 tx_ready is 1 only in WR_DATA; never asserted while tx_valid=0.
REQ-025 rd and wr are never simultaneously 1; each strobe lasts exactly one cycle.
REQ-026 regSel=01 in all states except RD_DATA and WR_DATA; busOut=0 except in WR_DATA.
REQ-027 rx_valid clears on the edge where rx_valid&rx_ready; a consume and a new capture in the same cycle are impossible (CAP_DATA only reachable with rx_valid=0).
REQ-028 Back-pressure: while rx_valid=1 the ACIA data register is never read; RDRF is ignored and TX servicing proceeds.
REQ-029 At most one data transfer per poll; minimum poll period POLL_GAP+2 cycles, data transfer adds one more (RD path two).
REQ-030 rx_data holds its value until the next capture; unchanged by consume.

Reset
REQ-031 During/after reset: state=GAP, gap counter=0, wr=0, rd=0, regSel=01, busOut=0, tx_ready=0, rx_valid=0, rx_data=0.
REQ-032 Reset asserted mid-transfer aborts it; an unissued wr does not occur; a captured-but-unconsumed rx byte is discarded.
REQ-033 First rd strobe occurs POLL_GAP cycles after reset deassertion.

Verification
REQ-034 Reset release, busIn=0x00, tx_valid=0 -> rd pulse with regSel=01 every POLL_GAP+2 cycles; wr never asserted.
REQ-035 Status 0x08, then data 0x41 -> rd regSel=01, rd regSel=00, rx_valid=1, rx_data=0x41 two cycles after data rd.
REQ-036 rx_valid=1, rx_ready=0, status 0x18, tx_valid=1, tx_data=0x5A -> no data read; wr=1, busOut=0x5A, tx_ready=1 for one cycle.
REQ-037 Status 0x18 with rx_valid=0 and tx_valid=1 -> RX serviced first; TX write follows on next poll.
REQ-038 Status 0x00, tx_valid=1 -> no wr, tx_ready stays 0 across 10 polls.
REQ-039 Reset asserted in CAP_DATA -> outputs at REQ-031 values same cycle; rx_valid=0 after release.
